// File: rtl/mux_arbiter.sv
// Two-way round-robin arbiter for a shared mux with a bounded hold time.
// Ports:
//   iClk  - rising-edge clock
//   iClr  - asynchronous active-low reset
//   iReqA - requester A wants the mux (level, held while wanted)
//   iReqB - requester B wants the mux (level, held while wanted)
//   oGntA - A owns the mux
//   oGntB - B owns the mux
//   oSel  - mux select, 0 = A, 1 = B
//   oEnb  - mux enable, high while either grant is high
//   oCnt  - cycles already spent in the current grant (saturating)
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CW       = 3
) (
    input  logic          iClk,
    input  logic          iClr,
    input  logic          iReqA,
    input  logic          iReqB,
    output logic          oGntA,
    output logic          oGntB,
    output logic          oSel,
    output logic          oEnb,
    output logic [CW-1:0] oCnt
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_A,
        GNT_B
    } state_t;

    localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    // 1 when B was the last requester served; resets to B so A wins the first tie.
    logic          last_b;

    always_ff @(posedge iClk or negedge iClr) begin
        if (!iClr) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (iReqA && (!iReqB || last_b)) begin
                        state  <= GNT_A;
                        last_b <= 1'b0;
                    end else if (iReqB) begin
                        state  <= GNT_B;
                        last_b <= 1'b1;
                    end
                end
                GNT_A: begin
                    // Leave on release, or rotate once the hold budget is spent.
                    if (!iReqA || (iReqB && cnt == CMAX)) begin
                        cnt <= '0;
                        if (iReqB) begin
                            state  <= GNT_B;
                            last_b <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt != CMAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GNT_B: begin
                    if (!iReqB || (iReqA && cnt == CMAX)) begin
                        cnt <= '0;
                        if (iReqA) begin
                            state  <= GNT_A;
                            last_b <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt != CMAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign oGntA = (state == GNT_A);
    assign oGntB = (state == GNT_B);
    assign oSel  = (state == GNT_B);
    assign oEnb  = (state == GNT_A) || (state == GNT_B);
    assign oCnt  = cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed scenarios plus random traffic.
// Expected outputs come from an owner/held-time model of the arbitration rules.
`timescale 1ns/1ps
module tb_mux_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CW       = 3;

    logic          iClk;
    logic          iClr;
    logic          iReqA;
    logic          iReqB;
    logic          oGntA;
    logic          oGntB;
    logic          oSel;
    logic          oEnb;
    logic [CW-1:0] oCnt;

    mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .iClk (iClk),
        .iClr (iClr),
        .iReqA(iReqA),
        .iReqB(iReqB),
        .oGntA(oGntA),
        .oGntB(oGntB),
        .oSel (oSel),
        .oEnb (oEnb),
        .oCnt (oCnt)
    );

    typedef struct {
        bit ga;
        bit gb;
        bit sel;
        bit en;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: owner 0 = none, 1 = A, 2 = B; held = cycles owned so far.
    int m_owner;
    int m_held;
    int m_last;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
    endtask

    task automatic model_step(input bit a, input bit b);
        int nxt;
        bit mine;
        bit other;
        int oid;
        if (m_owner == 0) begin
            if (a && b)  nxt = (m_last == 2) ? 1 : 2;
            else if (a)  nxt = 1;
            else if (b)  nxt = 2;
            else         nxt = 0;
        end else begin
            mine  = (m_owner == 1) ? a : b;
            other = (m_owner == 1) ? b : a;
            oid   = 3 - m_owner;
            if (!mine)                              nxt = other ? oid : 0;
            else if (other && m_held >= MAX_HOLD-1) nxt = oid;
            else                                    nxt = m_owner;
        end
        if (nxt != 0 && nxt == m_owner) begin
            m_held++;
        end else begin
            m_held = 0;
            if (nxt != 0) m_last = nxt;
        end
        m_owner = nxt;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ga  = (m_owner == 1);
        e.gb  = (m_owner == 2);
        e.sel = (m_owner == 2);
        e.en  = (m_owner != 0);
        e.cnt = (m_owner == 0) ? 0 :
                (m_held > MAX_HOLD-1 ? MAX_HOLD-1 : m_held);
        return e;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit a, input bit b);
        iReqA = a;
        iReqB = b;
        @(posedge iClk);
        model_step(a, b);
        q.push_back(model_out());
        @(negedge iClk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".gntA"}, int'(oGntA), 0);
        chk({nm, ".gntB"}, int'(oGntB), 0);
        chk({nm, ".sel"},  int'(oSel),  0);
        chk({nm, ".enb"},  int'(oEnb),  0);
        chk({nm, ".cnt"},  int'(oCnt),  0);
    endtask

    // Called at a negedge; asserts reset between edges and checks it acts at once.
    task automatic do_reset();
        #2;
        iClr = 1'b0;
        #1;
        chk_zero("rst_async");
        model_reset();
        @(posedge iClk);
        #1;
        chk_zero("rst_hold");
        @(negedge iClk);
        iClr = 1'b1;
    endtask

    // Monitor: compares DUT against the scoreboard after each rising edge.
    bit prev_a = 0;
    bit prev_b = 0;
    int wait_b = 0;
    int wait_a = 0;
    always @(posedge iClk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gntA", int'(oGntA), int'(e.ga));
            chk("gntB", int'(oGntB), int'(e.gb));
            chk("sel",  int'(oSel),  int'(e.sel));
            chk("enb",  int'(oEnb),  int'(e.en));
            chk("cnt",  int'(oCnt),  e.cnt);
        end
        chk("no_overlap", int'(oGntA && oGntB), 0);
        chk("enb_or", int'(oEnb), int'(oGntA | oGntB));
        // Requests visible now were sampled while the previous grant was held.
        wait_b = (prev_a && iReqB) ? wait_b + 1 : 0;
        wait_a = (prev_b && iReqA) ? wait_a + 1 : 0;
        if (wait_b > MAX_HOLD) chk("hold_bound_a", wait_b, MAX_HOLD);
        if (wait_a > MAX_HOLD) chk("hold_bound_b", wait_a, MAX_HOLD);
        prev_a = oGntA;
        prev_b = oGntB;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ra;
        bit rb;
        iClr  = 1'b0;
        iReqA = 1'b0;
        iReqB = 1'b0;
        model_reset();
        #1;
        chk_zero("reset");
        @(negedge iClk);
        @(negedge iClk);
        iClr = 1'b1;

        // Only A requests: grant next cycle, counter climbs and saturates.
        repeat (7) cycle(1, 0);
        cycle(0, 0);

        // Both from IDLE after reset: A first, forced rotation every MAX_HOLD.
        do_reset();
        repeat (14) cycle(1, 1);
        cycle(0, 0);

        // A drops at cnt=1 while B waits: direct hand-over, then round-robin tie.
        do_reset();
        cycle(1, 0);
        cycle(1, 1);
        cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);
        cycle(1, 1);
        cycle(1, 1);
        cycle(0, 0);

        // Late arrival while the owner is saturated takes the mux next edge.
        repeat (6) cycle(0, 1);
        cycle(1, 1);
        cycle(1, 1);
        cycle(0, 0);

        // Reset mid GNT_B at cnt=2, then a tie goes to A.
        do_reset();
        repeat (3) cycle(0, 1);
        do_reset();
        repeat (3) cycle(1, 1);

        // Random traffic with sticky requests.
        ra = 0;
        rb = 0;
        repeat (1000) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            cycle(ra, rb);
        end
        cycle(0, 0);

        @(negedge iClk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
